// File: rtl/pong_pkg.sv
// Shared types and helpers for the pong match controller and its sibling blocks.
package pong_pkg;

  localparam int unsigned MAX_PLAYERS = 4;
  localparam int unsigned MAX_SCORE_W = 16;
  localparam int unsigned PACK_W      = MAX_PLAYERS * MAX_SCORE_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_OVER
  } match_state_t;

  // Extract player idx's score from a packed score vector zero-extended to PACK_W.
  function automatic logic [MAX_SCORE_W-1:0] score_slice(input logic [PACK_W-1:0] packed_scores,
                                                         input int unsigned idx,
                                                         input int unsigned score_w);
    logic [PACK_W-1:0]      shifted;
    logic [MAX_SCORE_W-1:0] mask;
    shifted = packed_scores >> (idx * score_w);
    mask    = MAX_SCORE_W'((33'd1 << score_w) - 33'd1);
    return shifted[MAX_SCORE_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame tick from vsync falling edges plus a clearable, holdable frame counter.
module frame_timer
  import pong_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             vsync,
  input  logic             clr,
  input  logic             hold,
  output logic             frame_tick_c,
  output logic [CNT_W-1:0] frame_cnt
);

  logic vsync_q;

  assign frame_tick_c = vsync_q & ~vsync;

  // Clear wins over counting so a state entry always starts from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q   <= 1'b1;
      frame_cnt <= '0;
    end else begin
      vsync_q <= vsync;
      if (clr) begin
        frame_cnt <= '0;
      end else if (frame_tick_c && !hold) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/match_ctrl.sv
// Pong match sequencing: serve/play/point/game-over flow and score keeping.
// Define MATCH_CTRL_WIN_BY_TWO_EN to require a two-point lead to win.
module match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned WIN_SCORE    = 10,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned OVER_FRAMES  = 180
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          vsync,
  input  logic                          start,
  input  logic                          pause,
  input  logic [NUM_PLAYERS-1:0]        score_pulse,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic                          round_rst,
  output logic                          play_en,
  output logic [1:0]                    serve_to,
  output logic                          game_over,
  output logic [1:0]                    winner
);

  localparam int unsigned FRAME_MAX = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
  localparam int unsigned CNT_W     = $clog2(FRAME_MAX + 1);
  localparam int unsigned SCORES_W  = NUM_PLAYERS * SCORE_W;

  match_state_t          state_q, state_d;
  logic [SCORES_W-1:0]   scores_d;
  logic [1:0]            serve_to_d, winner_d, pt_idx_q, pt_idx_d, hit_idx;
  logic                  round_rst_d, play_en_d, game_over_d;
  logic                  new_match, win_c;
  logic [SCORE_W-1:0]    hit_score, pt_score;
  logic                  frame_tick_c, frame_clr_c, frame_hold_c;
  logic [CNT_W-1:0]      frame_cnt;

  frame_timer #(.CNT_W(CNT_W)) u_frame_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .vsync        (vsync),
    .clr          (frame_clr_c),
    .hold         (frame_hold_c),
    .frame_tick_c (frame_tick_c),
    .frame_cnt    (frame_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      scores    <= '0;
      round_rst <= 1'b0;
      play_en   <= 1'b0;
      serve_to  <= 2'd0;
      game_over <= 1'b0;
      winner    <= 2'd0;
      pt_idx_q  <= 2'd0;
    end else begin
      state_q   <= state_d;
      scores    <= scores_d;
      round_rst <= round_rst_d;
      play_en   <= play_en_d;
      serve_to  <= serve_to_d;
      game_over <= game_over_d;
      winner    <= winner_d;
      pt_idx_q  <= pt_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    scores_d    = scores;
    serve_to_d  = serve_to;
    winner_d    = winner;
    pt_idx_d    = pt_idx_q;
    round_rst_d = 1'b0;
    new_match   = 1'b0;
    hit_idx     = 2'd0;

    // Lowest set index wins a simultaneous score.
    for (int i = int'(NUM_PLAYERS) - 1; i >= 0; i--) begin
      if (score_pulse[i]) hit_idx = 2'(i);
    end
    hit_score = SCORE_W'(score_slice(PACK_W'(scores), 32'(hit_idx), SCORE_W));
    pt_score  = SCORE_W'(score_slice(PACK_W'(scores), 32'(pt_idx_q), SCORE_W));

    win_c = (pt_score >= SCORE_W'(WIN_SCORE));
`ifdef MATCH_CTRL_WIN_BY_TWO_EN
    for (int j = 0; j < int'(NUM_PLAYERS); j++) begin
      if ((2'(j) != pt_idx_q) &&
          ({1'b0, pt_score} < ({1'b0, SCORE_W'(score_slice(PACK_W'(scores), 32'(j), SCORE_W))}
                               + (SCORE_W+1)'(2)))) begin
        win_c = 1'b0;
      end
    end
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) new_match = 1'b1;
      end
      ST_SERVE: begin
        if (start) begin
          new_match = 1'b1;
        end else if (frame_tick_c && !pause && (frame_cnt == CNT_W'(SERVE_FRAMES - 1))) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (start) begin
          new_match = 1'b1;
        end else if (|score_pulse) begin
          state_d    = ST_POINT;
          pt_idx_d   = hit_idx;
          serve_to_d = hit_idx;
          for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
            if ((2'(i) == hit_idx) && (hit_score != {SCORE_W{1'b1}})) begin
              scores_d[i*SCORE_W +: SCORE_W] = hit_score + SCORE_W'(1);
            end
          end
        end
      end
      ST_POINT: begin
        if (start) begin
          new_match = 1'b1;
        end else if (win_c) begin
          state_d  = ST_OVER;
          winner_d = pt_idx_q;
        end else begin
          state_d     = ST_SERVE;
          round_rst_d = 1'b1;
        end
      end
      ST_OVER: begin
        if (start) begin
          new_match = 1'b1;
        end else if (frame_tick_c && (frame_cnt == CNT_W'(OVER_FRAMES - 1))) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (new_match) begin
      state_d     = ST_SERVE;
      scores_d    = '0;
      round_rst_d = 1'b1;
      serve_to_d  = 2'd0;
    end

    play_en_d    = (state_d == ST_PLAY) && !pause;
    game_over_d  = (state_d == ST_OVER);
    // Counter restarts on every state entry, including a restart back into SERVE.
    frame_clr_c  = new_match || (state_d != state_q);
    frame_hold_c = (state_q == ST_SERVE) ? pause : (state_q != ST_OVER);
  end

endmodule
